// File: rtl/xif_fp_pkg.sv
// Shared types and decode constants for the XIF floating-point offload queue.
package xif_fp_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned X_NUM_RS   = 2;
    localparam int unsigned X_ID_WIDTH = 4;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned RS_W       = X_NUM_RS * XLEN;

    // F-extension major opcodes accepted for offload
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_MADD     = 7'b1000011;
    localparam logic [6:0] OPC_MSUB     = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_NMADD    = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

    // OP-FP funct5 values whose result lands in an integer register
    localparam logic [4:0] F5_FMV_X_W_FCLASS = 5'b11100;
    localparam logic [4:0] F5_FCMP           = 5'b10100;
    localparam logic [4:0] F5_FCVT_W_S       = 5'b11000;

    typedef struct packed {
        logic [INSTR_W-1:0]    instr;
        logic [X_ID_WIDTH-1:0] id;
        logic [RS_W-1:0]       rs;
        logic                  committed;
        logic                  killed;
    } queue_entry_t;

endpackage

// File: rtl/xif_offload_queue_if.sv
// Issue, commit and dispatch channels between the core, the offload queue and the FPU.
interface xif_offload_queue_if;
    import xif_fp_pkg::*;

    logic                  issue_valid;
    logic                  issue_ready;
    logic [INSTR_W-1:0]    issue_instr;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic [RS_W-1:0]       issue_rs;
    logic [X_NUM_RS-1:0]   issue_rs_valid;
    logic                  issue_accept;
    logic                  issue_writeback;
    logic                  issue_loadstore;

    logic                  commit_valid;
    logic [X_ID_WIDTH-1:0] commit_id;
    logic                  commit_kill;

    logic                  dispatch_valid;
    logic                  dispatch_ready;
    logic [INSTR_W-1:0]    dispatch_instr;
    logic [X_ID_WIDTH-1:0] dispatch_id;
    logic [RS_W-1:0]       dispatch_rs;

    // Core / FPU side
    modport master (
        output issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
        output commit_valid, commit_id, commit_kill,
        output dispatch_ready,
        input  issue_ready, issue_accept, issue_writeback, issue_loadstore,
        input  dispatch_valid, dispatch_instr, dispatch_id, dispatch_rs
    );

    // Queue side
    modport slave (
        input  issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
        input  commit_valid, commit_id, commit_kill,
        input  dispatch_ready,
        output issue_ready, issue_accept, issue_writeback, issue_loadstore,
        output dispatch_valid, dispatch_instr, dispatch_id, dispatch_rs
    );

endinterface

// File: rtl/fp_offload_decoder.sv
// Combinational classification of an offered instruction as an F-extension op.
module fp_offload_decoder
    import xif_fp_pkg::*;
(
    input  logic       valid,
    input  logic [6:0] opcode,
    input  logic [4:0] funct5,
    output logic       accept_c,
    output logic       writeback_c,
    output logic       loadstore_c
);

    // Decode flags are only meaningful while an issue request is presented
    always_comb begin
        accept_c    = 1'b0;
        writeback_c = 1'b0;
        loadstore_c = 1'b0;
        if (valid) begin
            unique case (opcode)
                OPC_LOAD_FP, OPC_STORE_FP: begin
                    accept_c    = 1'b1;
                    loadstore_c = 1'b1;
                end
                OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
                    accept_c = 1'b1;
                end
                OPC_OP_FP: begin
                    accept_c    = 1'b1;
                    writeback_c = funct5 inside {F5_FMV_X_W_FCLASS, F5_FCMP, F5_FCVT_W_S};
                end
                default: begin
                    accept_c = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/xif_offload_queue.sv
// In-order offload queue: accepts FP instructions, holds them until commit/kill, dispatches to the FPU.
module xif_offload_queue
    import xif_fp_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4  // power of two, >= 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    xif_offload_queue_if.slave           xif,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    queue_entry_t            entries [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]        head_q;
    logic [PTR_W-1:0]        tail_q;
    logic [OCC_W-1:0]        count_q;
    logic                    ready_q;

    logic                    accept_c;
    logic                    writeback_c;
    logic                    loadstore_c;
    queue_entry_t            head_c;
    queue_entry_t            new_entry_c;
    logic                    head_live_c;
    logic                    dispatch_valid_c;
    logic                    pop_c;
    logic                    enq_c;
    logic [QUEUE_DEPTH-1:0]  match_c;
    logic [QUEUE_DEPTH-1:0]  id_hit_c;
    logic [OCC_W-1:0]        count_next_c;

    fp_offload_decoder u_decoder (
        .valid       (xif.issue_valid),
        .opcode      (xif.issue_instr[6:0]),
        .funct5      (xif.issue_instr[31:27]),
        .accept_c    (accept_c),
        .writeback_c (writeback_c),
        .loadstore_c (loadstore_c)
    );

    assign xif.issue_ready     = ready_q;
    assign xif.issue_accept    = accept_c;
    assign xif.issue_writeback = writeback_c;
    assign xif.issue_loadstore = loadstore_c;

    assign head_c              = entries[head_q];
    assign xif.dispatch_valid  = dispatch_valid_c;
    assign xif.dispatch_instr  = head_c.instr;
    assign xif.dispatch_id     = head_c.id;
    assign xif.dispatch_rs     = head_c.rs;
    assign occupancy           = count_q;

    // Head status: killed heads drain silently, committed heads wait for the FPU
    always_comb begin
        head_live_c      = valid_q[head_q];
        dispatch_valid_c = head_live_c && head_c.committed && !head_c.killed;
        pop_c            = head_live_c && (head_c.killed || (head_c.committed && xif.dispatch_ready));
        enq_c            = xif.issue_valid && ready_q && accept_c;
    end

    // CAM match of the commit ID against every live entry
    always_comb begin
        match_c  = '0;
        id_hit_c = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            match_c[i]  = xif.commit_valid && valid_q[i] && (entries[i].id == xif.commit_id);
            id_hit_c[i] = valid_q[i] && (entries[i].id == xif.issue_id);
        end
    end

    // New entry; a commit/kill arriving alongside its own issue lands here
    always_comb begin
        new_entry_c = '{instr:     xif.issue_instr,
                        id:        xif.issue_id,
                        rs:        xif.issue_rs,
                        committed: 1'b0,
                        killed:    1'b0};
        if (xif.commit_valid && (xif.commit_id == xif.issue_id)) begin
            if (xif.commit_kill) begin
                new_entry_c.killed = 1'b1;
            end else begin
                new_entry_c.committed = 1'b1;
            end
        end
    end

    // Occupancy follows the net enqueue/pop change
    always_comb begin
        count_next_c = count_q;
        unique case ({enq_c, pop_c})
            2'b10:   count_next_c = count_q + OCC_W'(1);
            2'b01:   count_next_c = count_q - OCC_W'(1);
            default: count_next_c = count_q;
        endcase
    end

    // Entry payload and commit/kill flags; liveness is tracked separately in valid_q
    always_ff @(posedge clk) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (match_c[i]) begin
                if (xif.commit_kill) begin
                    entries[i].killed <= 1'b1;
                end else begin
                    entries[i].committed <= 1'b1;
                end
            end
        end
        if (enq_c) begin
            entries[tail_q] <= new_entry_c;
        end
    end

    // Pointers, valid bits, occupancy and registered issue_ready (no pop-to-issue bypass)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (pop_c) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (enq_c) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            count_q <= count_next_c;
            ready_q <= (count_next_c != OCC_W'(QUEUE_DEPTH));
        end
    end

`ifndef SYNTHESIS
    // Core must not reuse an ID that is still held in the queue
    a_no_dup_id: assert property (@(posedge clk) disable iff (!rst_n)
        enq_c |-> !(|id_hit_c))
        else $error("duplicate in-flight offload id %0d", xif.issue_id);

    // Bookkeeping sanity: never enqueue when full, never pop when empty
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        enq_c |-> (count_q < OCC_W'(QUEUE_DEPTH)))
        else $error("offload queue overflow");

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        pop_c |-> (count_q != '0))
        else $error("offload queue underflow");
`endif

endmodule
